// File: rtl/frame_buffer_pingpong_if.sv
// Producer/display bus of the ping-pong frame buffer.
// The master side drives strobes and addresses. The slave side is the buffer itself.
interface frame_buffer_pingpong_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 16
);
  logic                  wr_i;
  logic [ADDR_WIDTH-1:0] addr_wr;
  logic [DATA_WIDTH-1:0] Data_in;
  logic                  wr_done_i;
  logic                  wr_ready_o;
  logic                  rd_i;
  logic [ADDR_WIDTH-1:0] addr_rd;
  logic                  rd_vsync_i;
  logic [DATA_WIDTH-1:0] Data_out;
  logic                  rd_valid_o;
  logic                  front_page_o;
  logic                  swap_o;
  logic                  addr_err_o;

  modport master (
    output wr_i, addr_wr, Data_in, wr_done_i, rd_i, addr_rd, rd_vsync_i,
    input  wr_ready_o, Data_out, rd_valid_o, front_page_o, swap_o, addr_err_o
  );

  modport slave (
    input  wr_i, addr_wr, Data_in, wr_done_i, rd_i, addr_rd, rd_vsync_i,
    output wr_ready_o, Data_out, rd_valid_o, front_page_o, swap_o, addr_err_o
  );
endinterface

// File: rtl/frame_buffer_pingpong.sv
// Double-buffered frame store. The back page is filled while the front page is displayed.
// The pages swap when a completed frame meets the display vsync.
module frame_buffer_pingpong #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 16,
  parameter int NUMBER_BRAM = 10,
  parameter int DEPTH_SIZE  = 1024
) (
  input  logic                    clk_i,
  input  logic                    resetn_i,
  frame_buffer_pingpong_if.slave  bus
);
  localparam int FRAME_WORDS = NUMBER_BRAM * DEPTH_SIZE;
  localparam int N_BANKS     = 2 * NUMBER_BRAM;
  localparam int OFF_W       = $clog2(DEPTH_SIZE);
  localparam int BANK_W      = $clog2(N_BANKS);

  typedef enum logic {S_FILL, S_READY} state_e;

  state_e state_q, state_d;
  logic   front_page_q, front_page_d;
  logic   swap_q, swap_d;
  logic   addr_err_q, addr_err_d;
  logic   rd_vld1_q, rd_vld1_d;
  logic   rd_err1_q, rd_err1_d;
  logic   [BANK_W-1:0] rd_bank1_q, rd_bank1_d;
  logic   rd_valid_q, rd_valid_d;
  logic   [DATA_WIDTH-1:0] data_out_q, data_out_d;

  logic   wr_ready, swap_now;
  logic   wr_in_range, rd_in_range, wr_en, rd_en;
  logic   [BANK_W-1:0] wr_phys, rd_phys;
  logic   [OFF_W-1:0]  wr_off, rd_off;
  logic   [N_BANKS-1:0] wr_sel, rd_sel;
  logic   [DATA_WIDTH-1:0] bank_dout [N_BANKS];
  logic   [DATA_WIDTH-1:0] bank_mux;

  // ---------------- control FSM ----------------
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) state_q <= S_FILL;
    else           state_q <= state_d;
  end

  // NOTE: every signal written in a combinational block gets a default first, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FILL:  if (bus.wr_done_i && !bus.rd_vsync_i) state_d = S_READY;
      S_READY: if (bus.rd_vsync_i)                   state_d = S_FILL;
      default: state_d = S_FILL;
    endcase
  end

  // A frame completing on the vsync cycle itself swaps at once instead of waiting a frame.
  always_comb begin
    wr_ready = (state_q == S_FILL);
    swap_now = bus.rd_vsync_i && ((state_q == S_READY) || bus.wr_done_i);
  end

  // ---------------- address decode ----------------
  assign wr_in_range = bus.addr_wr < ADDR_WIDTH'(FRAME_WORDS);
  assign rd_in_range = bus.addr_rd < ADDR_WIDTH'(FRAME_WORDS);
  assign wr_en       = bus.wr_i && wr_ready && wr_in_range;
  assign rd_en       = bus.rd_i && rd_in_range;
  assign wr_off      = bus.addr_wr[OFF_W-1:0];
  assign rd_off      = bus.addr_rd[OFF_W-1:0];
  assign wr_phys     = bus.addr_wr[OFF_W +: BANK_W] + (front_page_q ? '0 : BANK_W'(NUMBER_BRAM));
  assign rd_phys     = bus.addr_rd[OFF_W +: BANK_W] + (front_page_q ? BANK_W'(NUMBER_BRAM) : '0);

  always_comb begin
    wr_sel = '0;
    rd_sel = '0;
    if (wr_en) wr_sel[wr_phys] = 1'b1;
    if (rd_en) rd_sel[rd_phys] = 1'b1;
  end

  // ---------------- banks: one write port, one registered read port each ----------------
  for (genvar b = 0; b < N_BANKS; b++) begin : g_bank
    logic [DATA_WIDTH-1:0] mem [DEPTH_SIZE];
    logic [DATA_WIDTH-1:0] dout;
    // NOTE: the memory and its output register have no reset, so they map onto block RAM; frame contents survive reset.
    always_ff @(posedge clk_i) begin
      if (wr_sel[b]) mem[wr_off] <= bus.Data_in;
      if (rd_sel[b]) dout        <= mem[rd_off];
    end
    assign bank_dout[b] = dout;
  end

  always_comb begin
    bank_mux = '0;
    for (int i = 0; i < N_BANKS; i++) begin
      if (rd_bank1_q == BANK_W'(i)) bank_mux = bank_dout[i];
    end
  end

  // ---------------- datapath / status registers ----------------
  always_comb begin
    front_page_d = front_page_q ^ swap_now;
    swap_d       = swap_now;
    addr_err_d   = addr_err_q
                 | (bus.rd_i && !rd_in_range)
                 | (bus.wr_i && wr_ready && !wr_in_range);
    rd_vld1_d    = bus.rd_i;
    rd_err1_d    = bus.rd_i && !rd_in_range;
    rd_bank1_d   = rd_phys;
    rd_valid_d   = rd_vld1_q;
    data_out_d   = data_out_q;
    if (rd_vld1_q) data_out_d = rd_err1_q ? '0 : bank_mux;
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops update together at the edge.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      front_page_q <= 1'b0;
      swap_q       <= 1'b0;
      addr_err_q   <= 1'b0;
      rd_vld1_q    <= 1'b0;
      rd_err1_q    <= 1'b0;
      rd_bank1_q   <= '0;
      rd_valid_q   <= 1'b0;
      data_out_q   <= '0;
    end else begin
      front_page_q <= front_page_d;
      swap_q       <= swap_d;
      addr_err_q   <= addr_err_d;
      rd_vld1_q    <= rd_vld1_d;
      rd_err1_q    <= rd_err1_d;
      rd_bank1_q   <= rd_bank1_d;
      rd_valid_q   <= rd_valid_d;
      data_out_q   <= data_out_d;
    end
  end

  assign bus.wr_ready_o   = wr_ready;
  assign bus.Data_out     = data_out_q;
  assign bus.rd_valid_o   = rd_valid_q;
  assign bus.front_page_o = front_page_q;
  assign bus.swap_o       = swap_q;
  assign bus.addr_err_o   = addr_err_q;
endmodule

// File: tb/tb_frame_buffer_pingpong.sv
// Directed bench for frame_buffer_pingpong. Reads push the expected word and due cycle into a queue.
// A monitor process pops and compares whenever rd_valid_o is seen.
module tb_frame_buffer_pingpong;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  typedef struct {
    logic [15:0] data;
    int          due;
  } exp_t;
  exp_t sb[$];

  frame_buffer_pingpong_if #(.ADDR_WIDTH(32), .DATA_WIDTH(16)) bus ();

  frame_buffer_pingpong #(
    .ADDR_WIDTH(32), .DATA_WIDTH(16), .NUMBER_BRAM(10), .DEPTH_SIZE(1024)
  ) dut (
    .clk_i    (clk),
    .resetn_i (resetn),
    .bus      (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [15:0] d);
    bus.wr_i = 1'b1; bus.addr_wr = a; bus.Data_in = d;
    tick();
    bus.wr_i = 1'b0;
  endtask

  task automatic issue_rd(input logic [31:0] a, input logic [15:0] exp);
    exp_t e;
    bus.rd_i = 1'b1; bus.addr_rd = a;
    e.data = exp; e.due = cyc + 2;
    sb.push_back(e);
    tick();
    bus.rd_i = 1'b0;
  endtask

  task automatic pulse_done();
    bus.wr_done_i = 1'b1;
    tick();
    bus.wr_done_i = 1'b0;
  endtask

  task automatic pulse_vsync();
    bus.rd_vsync_i = 1'b1;
    tick();
    bus.rd_vsync_i = 1'b0;
  endtask

  // Scoreboard monitor.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (resetn) begin
        if (bus.rd_valid_o) begin
          if (sb.size() == 0) begin
            check("rd_unexpected_valid", {31'd0, bus.rd_valid_o}, 32'd0);
          end else begin
            e = sb.pop_front();
            check("rd_data", {16'd0, bus.Data_out}, {16'd0, e.data});
            check("rd_latency", cyc, e.due);
          end
        end else if (sb.size() != 0 && sb[0].due <= cyc) begin
          check("rd_missing_valid", {31'd0, bus.rd_valid_o}, 32'd1);
          void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    bus.wr_i = 0; bus.addr_wr = '0; bus.Data_in = '0; bus.wr_done_i = 0;
    bus.rd_i = 0; bus.addr_rd = '0; bus.rd_vsync_i = 0;

    // Reset values.
    tick(); tick();
    check("rst_wr_ready", {31'd0, bus.wr_ready_o}, 32'd1);
    check("rst_rd_valid", {31'd0, bus.rd_valid_o}, 32'd0);
    check("rst_data_out", {16'd0, bus.Data_out}, 32'd0);
    check("rst_swap", {31'd0, bus.swap_o}, 32'd0);
    check("rst_front", {31'd0, bus.front_page_o}, 32'd0);
    check("rst_addr_err", {31'd0, bus.addr_err_o}, 32'd0);
    #3 resetn = 1'b1;
    tick();

    // Fill page 1, complete, then swap on vsync.
    wr(0, 16'hAAAA);
    wr(1023, 16'h5555);
    wr(1024, 16'hBBBB);
    wr(9216, 16'hFFFF);
    pulse_done();
    check("done_wr_ready_low", {31'd0, bus.wr_ready_o}, 32'd0);
    check("done_no_swap", {31'd0, bus.swap_o}, 32'd0);
    pulse_vsync();
    check("swap1_pulse", {31'd0, bus.swap_o}, 32'd1);
    check("swap1_front", {31'd0, bus.front_page_o}, 32'd1);
    check("swap1_wr_ready", {31'd0, bus.wr_ready_o}, 32'd1);
    tick();
    check("swap1_pulse_end", {31'd0, bus.swap_o}, 32'd0);
    issue_rd(0, 16'hAAAA);
    issue_rd(1023, 16'h5555);
    issue_rd(1024, 16'hBBBB);
    issue_rd(9216, 16'hFFFF);
    repeat (3) tick();

    // Fill page 0; a write while READY is dropped without error.
    wr(0, 16'h0A0A);
    wr(2047, 16'h1111);
    pulse_done();
    check("ready_wr_ready_low", {31'd0, bus.wr_ready_o}, 32'd0);
    wr(0, 16'h1234);
    check("ready_drop_no_err", {31'd0, bus.addr_err_o}, 32'd0);
    pulse_vsync();
    check("swap2_pulse", {31'd0, bus.swap_o}, 32'd1);
    check("swap2_front", {31'd0, bus.front_page_o}, 32'd0);
    check("swap2_wr_ready", {31'd0, bus.wr_ready_o}, 32'd1);
    issue_rd(0, 16'h0A0A);

    // Vsync without a completed frame: front page repeats.
    pulse_vsync();
    check("vsync_only_no_swap", {31'd0, bus.swap_o}, 32'd0);
    check("vsync_only_front", {31'd0, bus.front_page_o}, 32'd0);
    issue_rd(2047, 16'h1111);
    repeat (3) tick();

    // Write + done + vsync + read in one cycle: write hits old back page, read uses old front.
    bus.wr_i = 1; bus.addr_wr = 2047; bus.Data_in = 16'hCCCC;
    bus.wr_done_i = 1; bus.rd_vsync_i = 1;
    issue_rd(0, 16'h0A0A);
    bus.wr_i = 0; bus.wr_done_i = 0; bus.rd_vsync_i = 0;
    check("swap3_pulse", {31'd0, bus.swap_o}, 32'd1);
    check("swap3_front", {31'd0, bus.front_page_o}, 32'd1);
    check("swap3_stay_fill", {31'd0, bus.wr_ready_o}, 32'd1);
    issue_rd(2047, 16'hCCCC);
    check("swap3_pulse_end", {31'd0, bus.swap_o}, 32'd0);
    repeat (3) tick();

    // Back-to-back reads, then hold, then out-of-range accesses.
    issue_rd(0, 16'hAAAA);
    issue_rd(1023, 16'h5555);
    issue_rd(1024, 16'hBBBB);
    issue_rd(2047, 16'hCCCC);
    issue_rd(9216, 16'hFFFF);
    repeat (3) tick();
    check("hold_data_out", {16'd0, bus.Data_out}, 32'h0000FFFF);
    check("hold_rd_valid", {31'd0, bus.rd_valid_o}, 32'd0);
    issue_rd(10240, 16'h0000);
    check("oor_rd_err", {31'd0, bus.addr_err_o}, 32'd1);
    wr(10240, 16'hDEAD);
    issue_rd(0, 16'hAAAA);
    repeat (3) tick();
    check("oor_err_sticky", {31'd0, bus.addr_err_o}, 32'd1);

    // Reset while READY: pending swap discarded, memory retained.
    wr(5, 16'h7777);
    pulse_done();
    check("pre_rst_wr_ready", {31'd0, bus.wr_ready_o}, 32'd0);
    #3 resetn = 1'b0;
    #1;
    check("arst_front", {31'd0, bus.front_page_o}, 32'd0);
    check("arst_wr_ready", {31'd0, bus.wr_ready_o}, 32'd1);
    check("arst_addr_err", {31'd0, bus.addr_err_o}, 32'd0);
    check("arst_data_out", {16'd0, bus.Data_out}, 32'd0);
    check("arst_rd_valid", {31'd0, bus.rd_valid_o}, 32'd0);
    tick(); tick();
    #3 resetn = 1'b1;
    tick();
    pulse_vsync();
    check("post_rst_no_swap", {31'd0, bus.swap_o}, 32'd0);
    check("post_rst_front", {31'd0, bus.front_page_o}, 32'd0);
    issue_rd(5, 16'h7777);
    issue_rd(0, 16'h0A0A);
    issue_rd(2047, 16'h1111);
    repeat (4) tick();
    check("sb_drained", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/frame_buffer_pingpong.md
# frame_buffer_pingpong

Double-buffered successor to the banked frame buffer: two frame pages of NUMBER_BRAM × DEPTH_SIZE words each, one written by the pixel producer (back page) while the display side reads the other (front page). A write-side "frame done" and a read-side vertical sync together trigger a tear-free page swap. It adds registered read-valid signalling, write back-pressure and sticky address-error reporting, and sits between the capture/render pipeline and the video timing/readout logic.

## Interface
- ADDR_WIDTH, 32, width of addr_wr / addr_rd (word addresses within one page)
- DATA_WIDTH, 16, pixel word width
- NUMBER_BRAM, 10, BRAM banks per page (page holds FRAME_WORDS = NUMBER_BRAM × DEPTH_SIZE words)
- DEPTH_SIZE, 1024, words per bank; must be a power of two

- clk_i  in  1  single clock; all logic on rising edge
- resetn_i  in  1  asynchronous, active-low reset
- wr_i  in  1  write strobe
- addr_wr  in  ADDR_WIDTH  write word address in back page
- Data_in  in  DATA_WIDTH  write data
- wr_done_i  in  1  one-cycle pulse: back page complete
- wr_ready_o  out  1  1 = writes accepted (state FILL)
- rd_i  in  1  read strobe
- addr_rd  in  ADDR_WIDTH  read word address in front page
- rd_vsync_i  in  1  one-cycle pulse at display frame boundary
- Data_out  out  DATA_WIDTH  read data, valid when rd_valid_o = 1
- rd_valid_o  out  1  read data qualifier
- front_page_o  out  1  index of page currently read (0/1)
- swap_o  out  1  one-cycle pulse, cycle after a swap
- addr_err_o  out  1  sticky: an out-of-range read or write was seen

## Operation
- Address split: bank = addr / DEPTH_SIZE, offset = addr mod DEPTH_SIZE; physical bank = page × NUMBER_BRAM + bank. 2 × NUMBER_BRAM banks total, one write port and one read port each.
- Write accepted iff wr_i = 1, wr_ready_o = 1 and addr_wr < FRAME_WORDS; goes to back page (= ~front_page_o).
- Out-of-range address (≥ FRAME_WORDS) on wr_i or rd_i: no memory write; read returns 0 with rd_valid_o = 1; addr_err_o sets and holds until reset.
- Control FSM (two states):
  - FILL: wr_ready_o = 1. wr_done_i = 1 → READY, unless rd_vsync_i = 1 same cycle → swap, stay FILL.
  - READY: wr_ready_o = 0, writes dropped silently (no error). rd_vsync_i = 1 → swap, → FILL. Further wr_done_i ignored.
  - rd_vsync_i in FILL without wr_done_i: no swap; front page repeats.
- Swap: front_page_o toggles, swap_o = 1 next cycle.
- A write accepted in the same cycle as wr_done_i lands in the old back page before the swap.
- Reset values: FSM = FILL, front_page_o = 0, wr_ready_o = 1 (after reset release), rd_valid_o = 0, Data_out = 0, swap_o = 0, addr_err_o = 0. Memory contents not cleared; reset mid-frame abandons any pending swap.

## Timing
- Write: data in BRAM at rising edge where accepted; readable by any later-issued read of that page once it is front.
- Read latency 2 cycles: rd_i at edge N → BRAM registered output at N+1 → bank-mux output register at N+2; Data_out/rd_valid_o asserted for one cycle per rd_i (fully pipelined, one read per cycle).
- Reads issued in the swap cycle (rd_vsync_i edge) use the old front page; reads from the next cycle use the new front page; in-flight reads complete from the page they were issued to.
- Data_out holds last value when rd_valid_o = 0.
- wr_ready_o drops the cycle after wr_done_i (if no swap) and rises the cycle after the swapping rd_vsync_i.
- swap_o and front_page_o change on the same edge.

## Test plan
- Reset, write 0xAAAA @0, 0x5555 @1023, 0xBBBB @1024, 0xFFFF @9216 to page 1 (back); wr_done_i; rd_vsync_i → swap_o pulse, front_page_o = 1; reads return those values exactly 2 cycles after each rd_i, rd_valid_o aligned.
- After wr_done_i with no vsync: wr_ready_o = 0, write 0x1234 @0 dropped; after vsync, back page (0) address 0 still holds prior data, wr_ready_o = 1.
- wr_done_i and rd_vsync_i in same cycle together with a write 0xCCCC @2047 → immediate swap; read @2047 on new front returns 0xCCCC.
- rd_vsync_i with no wr_done_i → no swap_o, front_page_o unchanged, reads unchanged.
- Back-to-back reads @0,1023,1024,2047 on consecutive cycles → four consecutive valid outputs in order; read @10240 → Data_out = 0, addr_err_o = 1 and stays 1; write @10240 → no memory corruption.
- Assert resetn_i low while READY → outputs return to reset values asynchronously, pending swap discarded, front_page_o = 0, previously written page data still readable after release.
